// File: rtl/dbg_uart_pkg.sv
// Shared types and constants for the debug UART receive path.
package dbg_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int DataBits   = 8;
  localparam int MinDivider = 4;

endpackage

// File: rtl/dbg_uart_rx_if.sv
// Byte receiver bus from the UART receiver to dbg_decoder.
interface dbg_uart_rx_if import dbg_uart_pkg::*; ();

  logic                valid_data;
  logic [DataBits-1:0] data;
  logic                busy;
  logic                error_detected;

  modport master (output valid_data, output data, output busy, output error_detected);
  modport slave  (input  valid_data, input  data, input  busy, input  error_detected);

endinterface

// File: rtl/dbg_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs.
module dbg_sync2 #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dbg_uart_rx.sv
// UART byte receiver: start validation, mid-bit sampling, optional parity, stop check.
// State table:
//   IDLE   | waiting for a falling edge on an armed line
//   START  | waiting half a bit to confirm the start bit
//   DATA   | sampling 8 data bits LSB first
//   PARITY | sampling the parity bit
//   STOP   | sampling the stop bit, then reporting the byte or an error
module dbg_uart_rx import dbg_uart_pkg::*; #(
  parameter int BAUD_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic [BAUD_WIDTH-1:0] baud_divider,
  input  logic                  parity_en,
  input  logic                  parity_type_odd,
  dbg_uart_rx_if.master         recv
);

  logic                  rx_s;
  logic [1:0]            settle;
  state_t                state;
  logic                  armed;
  logic [BAUD_WIDTH-1:0] div_lat;
  logic [BAUD_WIDTH-1:0] baud_cnt;
  logic [3:0]            bit_cnt;
  logic                  par_en_lat;
  logic                  par_odd_lat;
  logic                  par_err;
  logic [DataBits-1:0]   shift;
  logic                  valid_q;
  logic                  error_q;
  logic                  busy_q;
  logic [DataBits-1:0]   data_q;

  logic [BAUD_WIDTH-1:0] div_clamped;
  logic                  tick;

  dbg_sync2 #(.RESET_VALUE(1'b1)) u_sync_rx (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign div_clamped = (baud_divider < BAUD_WIDTH'(MinDivider)) ? BAUD_WIDTH'(MinDivider)
                                                                : baud_divider;
  assign tick = (state == START) ? (baud_cnt == (div_lat >> 1) - 1'b1)
                                 : (baud_cnt == div_lat - 1'b1);

  // settle keeps the synchroniser's reset value from arming the line; only a real high counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle      <= 2'b00;
      state       <= IDLE;
      armed       <= 1'b0;
      div_lat     <= BAUD_WIDTH'(MinDivider);
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      par_en_lat  <= 1'b0;
      par_odd_lat <= 1'b0;
      par_err     <= 1'b0;
      shift       <= '0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      settle   <= {settle[0], 1'b1};
      baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
      if (rx_s && settle[1]) armed <= 1'b1;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (armed && !rx_s) begin
            div_lat     <= div_clamped;
            par_en_lat  <= parity_en;
            par_odd_lat <= parity_type_odd;
            bit_cnt     <= '0;
            par_err     <= 1'b0;
            busy_q      <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          if (tick) begin
            if (rx_s) begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift   <= {rx_s, shift[DataBits-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'(DataBits - 1)) state <= par_en_lat ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (tick) begin
            par_err <= ((^shift) ^ rx_s) != par_odd_lat;
            state   <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            busy_q <= 1'b0;
            state  <= IDLE;
            if (!rx_s || par_err) begin
              error_q <= 1'b1;
            end else begin
              valid_q <= 1'b1;
              data_q  <= shift;
            end
            if (!rx_s) armed <= 1'b0;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign recv.valid_data     = valid_q;
  assign recv.error_detected = error_q;
  assign recv.busy           = busy_q;
  assign recv.data           = data_q;

endmodule

// File: tb/tb_dbg_uart_rx.sv
// Self-checking bench for dbg_uart_rx with a pulse scoreboard.
module tb_dbg_uart_rx;
  import dbg_uart_pkg::*;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        rx;
  logic [11:0] baud_divider;
  logic        parity_en;
  logic        parity_type_odd;

  int checks;
  int errors;
  int cyc;
  int busy_cycles;
  exp_t exp_q[$];
  int valid_cyc[$];
  logic [7:0] last_good;

  dbg_uart_rx_if recv_if ();

  dbg_uart_rx #(.BAUD_WIDTH(12)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx              (rx),
    .baud_divider    (baud_divider),
    .parity_en       (parity_en),
    .parity_type_odd (parity_type_odd),
    .recv            (recv_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (recv_if.busy) busy_cycles++;
      if (recv_if.valid_data || recv_if.error_detected) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse valid=%0b err=%0b data=%02h",
                   recv_if.valid_data, recv_if.error_detected, recv_if.data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (recv_if.valid_data !== !e.is_err || recv_if.error_detected !== e.is_err ||
              recv_if.data !== e.data || recv_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL pulse got valid=%0b err=%0b data=%02h busy=%0b want valid=%0b err=%0b data=%02h busy=0",
                     recv_if.valid_data, recv_if.error_detected, recv_if.data, recv_if.busy,
                     !e.is_err, e.is_err, e.data);
          end
        end
        if (recv_if.valid_data) valid_cyc.push_back(cyc);
      end
    end
  end

  task automatic drive_bit(input logic v, input int d);
    rx = v;
    repeat (d) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int d, input bit par_on,
                            input bit par_bit, input bit stop_bit);
    drive_bit(1'b0, d);
    for (int i = 0; i < 8; i++) drive_bit(b[i], d);
    if (par_on) drive_bit(par_bit, d);
    drive_bit(stop_bit, d);
  endtask

  function automatic bit parity_ok(input logic [7:0] b, input bit par_bit, input bit odd);
    int ones;
    ones = $countones(b) + int'(par_bit);
    return odd ? (ones % 2 == 1) : (ones % 2 == 0);
  endfunction

  task automatic push_exp(input bit is_err, input logic [7:0] b);
    exp_t e;
    e.is_err = is_err;
    e.data   = is_err ? last_good : b;
    if (!is_err) last_good = b;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain_timeout pending=%0d want 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (8) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx = 1'b0;
    baud_divider = 12'd16;
    parity_en = 1'b0;
    parity_type_odd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (recv_if.valid_data !== 1'b0 || recv_if.data !== 8'h00 ||
        recv_if.busy !== 1'b0 || recv_if.error_detected !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b d=%02h b=%0b e=%0b want 0 00 0 0",
               recv_if.valid_data, recv_if.data, recv_if.busy, recv_if.error_detected);
    end
    @(posedge clk);
    rst = 1'b1;
    busy_cycles = 0;
    // a line held low out of reset must never start a frame
    repeat (40) @(posedge clk);
    checks++;
    if (busy_cycles !== 0) begin
      errors++;
      $display("FAIL low_from_reset busy_cycles=%0d want 0", busy_cycles);
    end
    drive_bit(1'b1, 20);
  endtask

  task automatic test_basic_8n1();
    busy_cycles = 0;
    push_exp(1'b0, 8'hA5);
    send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, 16);
    drain("basic_8n1", 200);
    // busy spans t0+1 .. stop sample = D/2 + 9*D cycles
    checks++;
    if (busy_cycles !== 8 + 9 * 16) begin
      errors++;
      $display("FAIL basic_busy_len got %0d want %0d", busy_cycles, 8 + 9 * 16);
    end
  endtask

  task automatic test_parity_even();
    parity_en = 1'b1;
    parity_type_odd = 1'b0;
    push_exp(!parity_ok(8'h3C, 1'b0, 1'b0), 8'h3C);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1);
    drive_bit(1'b1, 16);
    drain("even_good", 200);
    push_exp(!parity_ok(8'h3C, 1'b1, 1'b0), 8'h3C);
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1);
    drive_bit(1'b1, 16);
    drain("even_bad", 200);
    checks++;
    if (recv_if.data !== 8'h3C) begin
      errors++;
      $display("FAIL even_bad_data_held got %02h want 3C", recv_if.data);
    end
  endtask

  task automatic test_framing();
    baud_divider = 12'd10;
    parity_en = 1'b1;
    parity_type_odd = 1'b1;
    push_exp(1'b1, 8'h00);
    send_frame(8'h00, 10, 1'b1, 1'b1, 1'b0);
    drive_bit(1'b0, 30);
    drain("framing_err", 100);
    busy_cycles = 0;
    drive_bit(1'b0, 30);
    checks++;
    if (busy_cycles !== 0) begin
      errors++;
      $display("FAIL break_no_restart busy_cycles=%0d want 0", busy_cycles);
    end
    drive_bit(1'b1, 20);
    push_exp(!parity_ok(8'h5A, 1'b1, 1'b1), 8'h5A);
    send_frame(8'h5A, 10, 1'b1, 1'b1, 1'b1);
    drive_bit(1'b1, 10);
    drain("framing_recover", 200);
  endtask

  task automatic test_false_start();
    baud_divider = 12'd16;
    parity_en = 1'b0;
    busy_cycles = 0;
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 40);
    checks++;
    if (busy_cycles !== 8) begin
      errors++;
      $display("FAIL false_start_busy got %0d want 8", busy_cycles);
    end
    checks++;
    if (recv_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL false_start_idle busy=%0b want 0", recv_if.busy);
    end
  endtask

  task automatic test_back_to_back();
    baud_divider = 12'd8;
    valid_cyc.delete();
    push_exp(1'b0, 8'h01);
    push_exp(1'b0, 8'hFE);
    send_frame(8'h01, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFE, 8, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, 8);
    drain("b2b", 200);
    checks++;
    if (valid_cyc.size() != 2) begin
      errors++;
      $display("FAIL b2b_pulse_count got %0d want 2", valid_cyc.size());
    end else begin
      checks++;
      if (valid_cyc[1] - valid_cyc[0] != 80) begin
        errors++;
        $display("FAIL b2b_spacing got %0d want 80", valid_cyc[1] - valid_cyc[0]);
      end
    end
    baud_divider = 12'd2;
    push_exp(1'b0, 8'hC3);
    send_frame(8'hC3, 4, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, 8);
    drain("clamp_div2", 100);
  endtask

  task automatic test_reset_mid_frame();
    baud_divider = 12'd16;
    parity_en = 1'b0;
    fork
      send_frame(8'h77, 16, 1'b0, 1'b0, 1'b1);
      begin
        repeat (131) @(posedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (recv_if.valid_data !== 1'b0 || recv_if.data !== 8'h00 ||
            recv_if.busy !== 1'b0 || recv_if.error_detected !== 1'b0) begin
          errors++;
          $display("FAIL midframe_reset got v=%0b d=%02h b=%0b e=%0b want 0 00 0 0",
                   recv_if.valid_data, recv_if.data, recv_if.busy, recv_if.error_detected);
        end
        last_good = 8'h00;
        repeat (3) @(posedge clk);
        rst = 1'b1;
        busy_cycles = 0;
      end
    join
    drive_bit(1'b1, 40);
    checks++;
    if (busy_cycles !== 0) begin
      errors++;
      $display("FAIL midframe_remainder busy_cycles=%0d want 0", busy_cycles);
    end
    push_exp(1'b0, 8'h77);
    send_frame(8'h77, 16, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, 16);
    drain("after_reset_frame", 200);
    checks++;
    if (recv_if.data !== 8'h77) begin
      errors++;
      $display("FAIL after_reset_data got %02h want 77", recv_if.data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    busy_cycles = 0;
    last_good = 8'h00;
    test_reset();
    test_basic_8n1();
    test_parity_even();
    test_framing();
    test_false_start();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
